race_controller: RTL and testbench
==================================

Name: race_controller

Overview:
- Top-level sequencer for the race timer.
- Runs the start countdown, then gates the 1 Hz enable into the two-digit seconds display counter.
- Arbitrates the two players' finish inputs, flags false starts, and stops the race at the time limit.
- Sits between the user switches/buttons and the display counter, whose enable and clear it drives; countdown_digit feeds a seven-segment decoder.

Parameters:
- TICKS_PER_SEC, 50000000, clock cycles per one-second tick (set to 4 in simulation).
- COUNTDOWN_SECS, 3, countdown start value (1..9).
- TIME_LIMIT, 99, elapsed seconds at which the race times out (1..99).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock.
- start  in  1  level; rising edge starts or restarts a race.
- p1_finish  in  1  level; rising edge = player 1 finish.
- p2_finish  in  1  level; rising edge = player 2 finish.
- cnt_clear  out  1  one-cycle pulse; clears the display counter.
- cnt_enable  out  1  one-cycle count enable into the display counter.
- countdown_digit  out  4  current countdown value, 0 outside COUNTDOWN.
- state  out  3  IDLE=0, COUNTDOWN=1, RUNNING=2, FINISHED=3, TIMEOUT=4.
- go  out  1  high while RUNNING.
- winner  out  2  00 none, 01 P1, 10 P2, 11 tie.
- false_start  out  2  bit0 = P1, bit1 = P2; set by an edge during COUNTDOWN.
- timeout  out  1  high in TIMEOUT.

Behaviour:
- Reset:
  - state IDLE; every output 0; prescaler and elapsed counter 0.
  - Reset mid-race returns to IDLE on the next edge, with no cnt_clear pulse.
- Inputs are synchronous to clock (debounced upstream).
- Edge detect: X_rise = X & ~X_q, where X_q is a one-register delay.
  - An input sampled high at edge k (low at k-1) acts at edge k.
  - Registered outputs change after edge k.
- Prescaler:
  - Restart loads TICKS_PER_SEC-1, then counts down each cycle.
  - tick is high for the one cycle its value is 0; it then reloads.
  - First tick comes TICKS_PER_SEC cycles after restart.
- IDLE:
  - start_rise → COUNTDOWN.
  - On entry: countdown_digit=COUNTDOWN_SECS, prescaler restarted, elapsed=0, winner=0, false_start=0, cnt_clear high for exactly the first COUNTDOWN cycle.
- COUNTDOWN:
  - On tick with digit>1, decrement the digit.
  - On tick with digit==1:
    - digit=0.
    - If false_start==11 → FINISHED, winner=00.
    - Otherwise → RUNNING.
  - Pn_rise sets false_start[n-1]; it does not change state.
  - start_rise is ignored.
- RUNNING:
  - go=1.
  - Valid finish = Pn_rise from a player whose false_start bit is clear.
  - Priority, evaluated in the same cycle:
    1. Valid finish → FINISHED, winner = one-hot player, or 11 if both are valid in the same cycle.
    2. Else tick with elapsed==TIME_LIMIT → TIMEOUT.
    3. Else on tick, elapsed += 1.
  - cnt_enable = (state==RUNNING) & tick & no valid finish & ~(elapsed==TIME_LIMIT).
    - This is combinational from registered state.
    - The display freezes at the value shown at the finish/timeout cycle and never wraps 99→00.
  - start_rise is ignored.
- FINISHED / TIMEOUT:
  - Hold winner, false_start and timeout; cnt_enable=0; finish edges ignored.
  - start_rise → COUNTDOWN, with the same entry actions as from IDLE.
- Widths:
  - elapsed is 7 bits.
  - Prescaler is $clog2(TICKS_PER_SEC) bits.
  - countdown_digit compares unsigned.

Decomposition:
- Shared package race_pkg holds:
  - the state enum/localparams (IDLE..TIMEOUT);
  - the winner encodings (WIN_NONE, WIN_P1, WIN_P2, WIN_TIE);
  - the default TICKS_PER_SEC.
- One sub-module: tick_gen.
  - Parameter TICKS_PER_SEC.
  - Ports: clock, reset, restart, tick.
- FSM, edge detect and arbitration stay in race_controller.

Test Plan (TICKS_PER_SEC=4, COUNTDOWN_SECS=3, TIME_LIMIT=5):
1. start rises at edge 0 → cnt_clear high for 1 cycle; countdown_digit shows 3 for 4 cycles, then 2 for 4, then 1 for 4; state=RUNNING and go=1 after 12 cycles.
2. RUNNING, p1_finish rises after 2 ticks → cnt_enable pulsed exactly twice; state=FINISHED, winner=01, no further cnt_enable.
3. p1_finish and p2_finish rise in the same RUNNING cycle, coincident with a tick → winner=11; cnt_enable stays 0 that cycle.
4. p2_finish rises during COUNTDOWN → false_start=10; in RUNNING, p2 edges are ignored and p1 later wins with winner=01. Second run with both players false-starting → FINISHED with winner=00 at countdown end, go never asserted.
5. No finish → exactly 5 cnt_enable pulses, then on the 6th tick state=TIMEOUT, timeout=1, winner=00, display held at 05.
6. Reset asserted mid-COUNTDOWN → next cycle state=IDLE, all outputs 0. start while RUNNING is ignored. start in FINISHED restarts the countdown with a cnt_clear pulse, and winner and false_start cleared.

Source files
------------

// File: rtl/race_pkg.sv
// Shared definitions for the race timer: controller state encoding,
// winner encodings and the default prescaler length.
package race_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_RUNNING   = 3'd2,
    ST_FINISHED  = 3'd3,
    ST_TIMEOUT   = 3'd4
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  localparam int DEFAULT_TICKS_PER_SEC = 50000000;

endpackage

// File: rtl/race_controller_tick_gen.sv
// One-second tick prescaler. A restart reloads the counter so that the first
// tick lands exactly TICKS_PER_SEC cycles later; afterwards it free-runs.
module tick_gen
  import race_pkg::*;
#(
  parameter int TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] count;

  assign tick = (count == '0);

  // Down-counter: reload on restart or after the tick cycle, else decrement.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (restart || tick) begin
      count <= RELOAD;
    end else begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/race_controller.sv
// Race timer sequencer: start countdown, gated 1 Hz enable into the seconds
// display counter, finish arbitration, false-start flags and time limit.
module race_controller
  import race_pkg::*;
#(
  parameter int TICKS_PER_SEC  = DEFAULT_TICKS_PER_SEC,
  parameter int COUNTDOWN_SECS = 3,
  parameter int TIME_LIMIT     = 99
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       p1_finish,
  input  logic       p2_finish,
  output logic       cnt_clear,
  output logic       cnt_enable,
  output logic [3:0] countdown_digit,
  output logic [2:0] state,
  output logic       go,
  output logic [1:0] winner,
  output logic [1:0] false_start,
  output logic       timeout
);

  localparam logic [3:0] CD_START = 4'(COUNTDOWN_SECS);
  localparam logic [6:0] LIMIT    = 7'(TIME_LIMIT);

  state_t     state_r;
  logic [6:0] elapsed;
  logic       start_q, p1_q, p2_q;
  logic       start_rise, p1_rise, p2_rise;
  logic       p1_valid, p2_valid, any_valid;
  logic       at_limit;
  logic       restart;
  logic       tick;
  logic [1:0] fs_next;
  logic [1:0] fin_code;

  assign start_rise = start & ~start_q;
  assign p1_rise    = p1_finish & ~p1_q;
  assign p2_rise    = p2_finish & ~p2_q;

  // A finish only counts for a player who did not jump the countdown.
  assign p1_valid  = p1_rise & ~false_start[0];
  assign p2_valid  = p2_rise & ~false_start[1];
  assign any_valid = p1_valid | p2_valid;
  assign at_limit  = (elapsed == LIMIT);

  // Flags seen at the final countdown tick include an edge in that same cycle.
  assign fs_next = false_start | {p2_rise, p1_rise};

  assign restart = start_rise &&
                   (state_r != ST_COUNTDOWN) && (state_r != ST_RUNNING);

  // Counting stops on the finish/timeout cycle so the display freezes there.
  assign cnt_enable = (state_r == ST_RUNNING) & tick & ~any_valid & ~at_limit;

  assign state = state_r;

  // Winner encoding from the valid finishes of the current cycle.
  always_comb begin
    fin_code = WIN_NONE;
    unique case ({p2_valid, p1_valid})
      2'b01:   fin_code = WIN_P1;
      2'b10:   fin_code = WIN_P2;
      2'b11:   fin_code = WIN_TIE;
      default: fin_code = WIN_NONE;
    endcase
  end

  tick_gen #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_tick_gen (
    .clock  (clock),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  // One-register delay of the level inputs for rising-edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      start_q <= 1'b0;
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
    end else begin
      start_q <= start;
      p1_q    <= p1_finish;
      p2_q    <= p2_finish;
    end
  end

  // Race sequencer with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      elapsed         <= '0;
      cnt_clear       <= 1'b0;
      countdown_digit <= '0;
      go              <= 1'b0;
      winner          <= WIN_NONE;
      false_start     <= 2'b00;
      timeout         <= 1'b0;
    end else begin
      cnt_clear <= 1'b0;
      case (state_r)
        ST_IDLE, ST_FINISHED, ST_TIMEOUT: begin
          if (start_rise) begin
            state_r         <= ST_COUNTDOWN;
            countdown_digit <= CD_START;
            elapsed         <= '0;
            winner          <= WIN_NONE;
            false_start     <= 2'b00;
            timeout         <= 1'b0;
            go              <= 1'b0;
            cnt_clear       <= 1'b1;
          end
        end
        ST_COUNTDOWN: begin
          false_start <= fs_next;
          if (tick) begin
            if (countdown_digit > 4'd1) begin
              countdown_digit <= countdown_digit - 4'd1;
            end else begin
              countdown_digit <= '0;
              if (fs_next == 2'b11) begin
                state_r <= ST_FINISHED;
                winner  <= WIN_NONE;
              end else begin
                state_r <= ST_RUNNING;
                go      <= 1'b1;
              end
            end
          end
        end
        ST_RUNNING: begin
          if (any_valid) begin
            state_r <= ST_FINISHED;
            winner  <= fin_code;
            go      <= 1'b0;
          end else if (tick && at_limit) begin
            state_r <= ST_TIMEOUT;
            timeout <= 1'b1;
            go      <= 1'b0;
          end else if (tick) begin
            elapsed <= elapsed + 7'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          go      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_race_controller.sv
// Scoreboard bench for race_controller (TICKS_PER_SEC=4, COUNTDOWN_SECS=3,
// TIME_LIMIT=5). Stimulus queues the expected sequence of output events with
// the cycle distance between them; the monitor records an event whenever the
// held outputs change or a pulse output is high, and compares it in order.
module tb_race_controller;

  typedef struct packed {
    logic [2:0]  st;
    logic [3:0]  dig;
    logic        go;
    logic [1:0]  win;
    logic [1:0]  fs;
    logic        to;
    logic        clr;
    logic        en;
    int unsigned dt;
  } obs_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       start, p1_finish, p2_finish;
  logic       cnt_clear, cnt_enable, go, timeout;
  logic [3:0] countdown_digit;
  logic [2:0] state;
  logic [1:0] winner, false_start;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned last_cyc = 0;
  logic        mon_on    = 1'b0;
  logic        mon_first = 1'b1;
  logic [12:0] prev_snap = '0;
  obs_t        exp_q[$];

  race_controller #(
    .TICKS_PER_SEC (4),
    .COUNTDOWN_SECS(3),
    .TIME_LIMIT    (5)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .p1_finish      (p1_finish),
    .p2_finish      (p2_finish),
    .cnt_clear      (cnt_clear),
    .cnt_enable     (cnt_enable),
    .countdown_digit(countdown_digit),
    .state          (state),
    .go             (go),
    .winner         (winner),
    .false_start    (false_start),
    .timeout        (timeout)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic ex(input logic [2:0] st, input logic [3:0] dig, input logic g,
                    input logic [1:0] win, input logic [1:0] fs, input logic to,
                    input logic clr, input logic en, input int unsigned dt);
    obs_t o;
    o.st = st; o.dig = dig; o.go = g; o.win = win; o.fs = fs; o.to = to;
    o.clr = clr; o.en = en; o.dt = dt;
    exp_q.push_back(o);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor: sample away from the active edge and score each output event.
  always @(negedge clock) begin
    logic [12:0] snap;
    obs_t got, e;
    if (mon_on) begin
      snap = {state, countdown_digit, go, winner, false_start, timeout};
      if (mon_first || snap != prev_snap || cnt_clear || cnt_enable) begin
        got.st = state; got.dig = countdown_digit; got.go = go;
        got.win = winner; got.fs = false_start; got.to = timeout;
        got.clr = cnt_clear; got.en = cnt_enable;
        got.dt = mon_first ? 0 : cyc - last_cyc;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event at cycle %0d: st=%0d dig=%0d go=%0d win=%0d fs=%0d to=%0d clr=%0d en=%0d dt=%0d, required none",
                   cyc, got.st, got.dig, got.go, got.win, got.fs, got.to, got.clr, got.en, got.dt);
        end else begin
          e = exp_q.pop_front();
          if (got != e) begin
            n_fail++;
            $display("FAIL event at cycle %0d: got st=%0d dig=%0d go=%0d win=%0d fs=%0d to=%0d clr=%0d en=%0d dt=%0d, required st=%0d dig=%0d go=%0d win=%0d fs=%0d to=%0d clr=%0d en=%0d dt=%0d",
                     cyc, got.st, got.dig, got.go, got.win, got.fs, got.to, got.clr, got.en, got.dt,
                     e.st, e.dig, e.go, e.win, e.fs, e.to, e.clr, e.en, e.dt);
          end
        end
        last_cyc  = cyc;
        prev_snap = snap;
        mon_first = 1'b0;
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; p1_finish = 1'b0; p2_finish = 1'b0;
    // reset state
    ex(3'd0, 4'd0, 0, 2'd0, 2'd0, 0, 0, 0, 0);
    repeat (3) @(posedge clock);
    #1;
    reset  = 1'b0;
    mon_on = 1'b1;

    // countdown timing, then P1 wins after two ticks
    ex(3'd1, 4'd3, 0, 2'd0, 2'd0, 0, 1, 0, 1);
    ex(3'd1, 4'd2, 0, 2'd0, 2'd0, 0, 0, 0, 4);
    ex(3'd1, 4'd1, 0, 2'd0, 2'd0, 0, 0, 0, 4);
    ex(3'd2, 4'd0, 1, 2'd0, 2'd0, 0, 0, 0, 4);
    ex(3'd2, 4'd0, 1, 2'd0, 2'd0, 0, 0, 1, 3);
    ex(3'd2, 4'd0, 1, 2'd0, 2'd0, 0, 0, 1, 4);
    ex(3'd3, 4'd0, 0, 2'd1, 2'd0, 0, 0, 0, 2);
    start = 1'b1; cycles(1); start = 1'b0;
    cycles(20); p1_finish = 1'b1; cycles(1); p1_finish = 1'b0;
    cycles(6);

    // tie on a tick cycle: enable suppressed, winner 11
    ex(3'd1, 4'd3, 0, 2'd0, 2'd0, 0, 1, 0, 7);
    ex(3'd1, 4'd2, 0, 2'd0, 2'd0, 0, 0, 0, 4);
    ex(3'd1, 4'd1, 0, 2'd0, 2'd0, 0, 0, 0, 4);
    ex(3'd2, 4'd0, 1, 2'd0, 2'd0, 0, 0, 0, 4);
    ex(3'd2, 4'd0, 1, 2'd0, 2'd0, 0, 0, 1, 3);
    ex(3'd3, 4'd0, 0, 2'd3, 2'd0, 0, 0, 0, 5);
    start = 1'b1; cycles(1); start = 1'b0;
    cycles(19); p1_finish = 1'b1; p2_finish = 1'b1;
    cycles(1); p1_finish = 1'b0; p2_finish = 1'b0;
    cycles(3);

    // P2 false start; its RUNNING edge ignored; P1 wins
    ex(3'd1, 4'd3, 0, 2'd0, 2'd0, 0, 1, 0, 4);
    ex(3'd1, 4'd3, 0, 2'd0, 2'd2, 0, 0, 0, 3);
    ex(3'd1, 4'd2, 0, 2'd0, 2'd2, 0, 0, 0, 1);
    ex(3'd1, 4'd1, 0, 2'd0, 2'd2, 0, 0, 0, 4);
    ex(3'd2, 4'd0, 1, 2'd0, 2'd2, 0, 0, 0, 4);
    ex(3'd2, 4'd0, 1, 2'd0, 2'd2, 0, 0, 1, 3);
    ex(3'd2, 4'd0, 1, 2'd0, 2'd2, 0, 0, 1, 4);
    ex(3'd3, 4'd0, 0, 2'd1, 2'd2, 0, 0, 0, 2);
    start = 1'b1; cycles(1); start = 1'b0;
    cycles(2); p2_finish = 1'b1; cycles(1); p2_finish = 1'b0;
    cycles(13); p2_finish = 1'b1; cycles(1); p2_finish = 1'b0;
    cycles(3); p1_finish = 1'b1; cycles(1); p1_finish = 1'b0;
    cycles(2);

    // both false start: FINISHED with no winner, go never raised
    ex(3'd1, 4'd3, 0, 2'd0, 2'd0, 0, 1, 0, 3);
    ex(3'd1, 4'd3, 0, 2'd0, 2'd3, 0, 0, 0, 2);
    ex(3'd1, 4'd2, 0, 2'd0, 2'd3, 0, 0, 0, 2);
    ex(3'd1, 4'd1, 0, 2'd0, 2'd3, 0, 0, 0, 4);
    ex(3'd3, 4'd0, 0, 2'd0, 2'd3, 0, 0, 0, 4);
    start = 1'b1; cycles(1); start = 1'b0;
    cycles(1); p1_finish = 1'b1; p2_finish = 1'b1;
    cycles(1); p1_finish = 1'b0; p2_finish = 1'b0;
    cycles(12);

    // timeout: five enables, sixth tick times out
    ex(3'd1, 4'd3, 0, 2'd0, 2'd0, 0, 1, 0, 3);
    ex(3'd1, 4'd2, 0, 2'd0, 2'd0, 0, 0, 0, 4);
    ex(3'd1, 4'd1, 0, 2'd0, 2'd0, 0, 0, 0, 4);
    ex(3'd2, 4'd0, 1, 2'd0, 2'd0, 0, 0, 0, 4);
    ex(3'd2, 4'd0, 1, 2'd0, 2'd0, 0, 0, 1, 3);
    for (int i = 0; i < 4; i++) ex(3'd2, 4'd0, 1, 2'd0, 2'd0, 0, 0, 1, 4);
    ex(3'd4, 4'd0, 0, 2'd0, 2'd0, 1, 0, 0, 5);
    start = 1'b1; cycles(1); start = 1'b0;
    cycles(40);

    // restart from TIMEOUT, reset mid-countdown, start ignored while RUNNING,
    // restart from FINISHED
    ex(3'd1, 4'd3, 0, 2'd0, 2'd0, 0, 1, 0, 5);
    ex(3'd0, 4'd0, 0, 2'd0, 2'd0, 0, 0, 0, 3);
    ex(3'd1, 4'd3, 0, 2'd0, 2'd0, 0, 1, 0, 1);
    ex(3'd1, 4'd2, 0, 2'd0, 2'd0, 0, 0, 0, 4);
    ex(3'd1, 4'd1, 0, 2'd0, 2'd0, 0, 0, 0, 4);
    ex(3'd2, 4'd0, 1, 2'd0, 2'd0, 0, 0, 0, 4);
    ex(3'd2, 4'd0, 1, 2'd0, 2'd0, 0, 0, 1, 3);
    ex(3'd3, 4'd0, 0, 2'd2, 2'd0, 0, 0, 0, 2);
    ex(3'd1, 4'd3, 0, 2'd0, 2'd0, 0, 1, 0, 4);
    start = 1'b1; cycles(1); start = 1'b0;
    cycles(2); reset = 1'b1; cycles(1); reset = 1'b0;
    start = 1'b1; cycles(1); start = 1'b0;
    cycles(13); start = 1'b1; cycles(1); start = 1'b0;
    cycles(2); p2_finish = 1'b1; cycles(1); p2_finish = 1'b0;
    cycles(3); start = 1'b1; cycles(1); start = 1'b0;
    cycles(3);

    // every expected event must have been seen
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events: %0d expected events not seen, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
